avalon_onchip_ram_burst: RTL and testbench
==========================================

Name: avalon_onchip_ram_burst

Overview:
Parametrised single-port on-chip RAM with an Avalon-MM slave interface. It is the next generation of the system-controller scratch memory. Compared with the earlier block it adds configurable width, depth and read latency, an explicit read strobe with readdatavalid, and auto-incrementing read bursts with waitrequest back-pressure. It sits on the system-controller interconnect as a JTAG/CPU-accessible buffer for the 10G BASE-R debug path.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8.
ADDR_WIDTH, 8, word address width; DEPTH = 2**ADDR_WIDTH words.
READ_LATENCY, 1, cycles from read-beat issue to readdatavalid; legal values 1 or 2.
BURST_WIDTH, 4, burstcount width; maximum burst = 2**BURST_WIDTH-1 beats.

Ports:
clk  in  1  single clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
reset_req  in  1  reset-request; suppresses RAM clock enable, same as clken=0.
clken  in  1  clock enable.
chipselect  in  1  slave select.
address  in  ADDR_WIDTH  word address.
byteenable  in  DATA_WIDTH/8  byte lane enables for writes.
read  in  1  read request.
write  in  1  write request.
writedata  in  DATA_WIDTH  write data.
burstcount  in  BURST_WIDTH  read burst length; sampled on acceptance.
readdata  out  DATA_WIDTH  registered read data.
readdatavalid  out  1  one-cycle pulse per returned beat.
waitrequest  out  1  slave stall.

Behaviour:
- en = clken & ~reset_req. All state, pipeline and RAM updates occur only when en=1; otherwise everything holds.
- RAM contents are not reset; initial contents are undefined.
- Reset values: state=IDLE, readdata=0, readdatavalid=0, pipeline valid bits=0. waitrequest follows its equation below.
- waitrequest = (state==BURST) | ~en. It is combinational and is not gated by chipselect.
- Write accept: chipselect & write & ~waitrequest.
  - Lanes with byteenable=1 are written; other lanes are untouched.
  - burstcount is ignored for writes; writes are always single-beat.
- Read accept: chipselect & read & ~write & ~waitrequest. If read and write are both asserted, the write executes and the read is dropped.
- FSM IDLE:
  - On read accept, issue beat 0 at the same address in the same cycle. burstcount=0 is treated as 1.
  - If the effective count N>1: latch next_addr = address+1, remaining = N-1, and go to BURST.
- FSM BURST:
  - Each en cycle issues one beat at next_addr.
  - next_addr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
  - remaining decrements.
  - When the final beat issues (remaining==1), return to IDLE, where a new command is accepted on the next cycle.
- Issued beats enter a READ_LATENCY-deep valid/data pipeline.
  - readdata and readdatavalid update READ_LATENCY en-cycles after issue. A beat issued in cycle t with en held high gives readdatavalid=1 in cycle t+READ_LATENCY.
  - Back-to-back beats give back-to-back readdatavalid pulses.
  - When en=0, readdatavalid is forced to 0 and pending beats hold. They emerge in order once en returns. No beat is lost or duplicated.
  - readdata holds its last value when readdatavalid=0.
- Read-after-write: a read issued the cycle after a write to the same address returns the new data. A same-cycle read/write collision cannot occur because of the write priority above.
- Reset mid-burst: asynchronous abort to IDLE. Outstanding beats are discarded and readdatavalid=0 immediately. RAM contents are retained.

Test Plan:
1. Reset, then write 0xDEADBEEF to addr 5 with be=0xF, then read addr 5 with burstcount=1 -> readdatavalid pulse 1 cycle after issue (READ_LATENCY=1) with readdata=0xDEADBEEF; waitrequest=0 throughout.
2. Write 0x11223344 to addr 7; write 0xAABBCCDD to addr 7 with be=0x5; read addr 7 -> 0x11BB33DD.
3. Fill addr 0xFE, 0xFF, 0x00, 0x01 with 1, 2, 3, 4; read burst at addr 0xFE with burstcount=4 -> waitrequest=1 for 3 cycles after accept, four consecutive readdatavalid pulses with data 1, 2, 3, 4 (wrap check).
4. READ_LATENCY=2, burstcount=3 at addr 0x10, deassert clken for 2 cycles after the second beat issues -> readdatavalid=0 and waitrequest=1 during the stall; three beats delivered in order afterwards, with no extra pulses.
5. Assert read and write together at addr 3 with data 0x55 -> addr 3 reads back 0x55, and no readdatavalid results from the colliding cycle.
6. Start burst of 8, assert reset after beat 3 is returned -> readdatavalid=0 from reset onwards; after release waitrequest=0 and a single read at addr 0 completes normally; previously written data is intact.

Source files
------------

// File: rtl/avalon_onchip_ram_burst_if.sv
// Avalon-MM slave bus bundle for the burst-capable on-chip RAM.
// The master drives commands and write data; the slave returns read beats and stall.
interface avalon_onchip_ram_burst_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned BURST_WIDTH = 4
) ();
    logic                      chipselect;
    logic [ADDR_WIDTH-1:0]     address;
    logic [DATA_WIDTH/8-1:0]   byteenable;
    logic                      read;
    logic                      write;
    logic [DATA_WIDTH-1:0]     writedata;
    logic [BURST_WIDTH-1:0]    burstcount;
    logic [DATA_WIDTH-1:0]     readdata;
    logic                      readdatavalid;
    logic                      waitrequest;

    modport master (
        output chipselect, address, byteenable, read, write, writedata, burstcount,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  chipselect, address, byteenable, read, write, writedata, burstcount,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_onchip_ram_burst.sv
// Single-port on-chip RAM with Avalon-MM slave: byte-lane writes, auto-incrementing
// read bursts with waitrequest back-pressure, and a 1- or 2-deep read return pipeline.
module avalon_onchip_ram_burst #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BURST_WIDTH  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_req,
    input  logic clken,
    avalon_onchip_ram_burst_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LANES = DATA_WIDTH / 8;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [BURST_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    logic                    en;
    logic                    stall;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    issue;
    logic [ADDR_WIDTH-1:0]   issue_addr;

    assign en         = clken & ~reset_req;
    assign stall      = (state == BURST) | ~en;
    assign wr_acc     = bus.chipselect & bus.write & ~stall;
    // write wins a read/write collision, so a read is never issued alongside a write
    assign rd_acc     = bus.chipselect & bus.read & ~bus.write & ~stall;
    assign issue      = rd_acc | (en & (state == BURST));
    assign issue_addr = (state == BURST) ? next_addr : bus.address;

    assign bus.waitrequest   = stall;
    assign bus.readdata      = dat_q[READ_LATENCY-1];
    // a beat parked in the last stage while disabled is presented once en returns
    assign bus.readdatavalid = vld_q[READ_LATENCY-1] & en;

    // Burst sequencer: beat 0 issues from IDLE, the rest from BURST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            next_addr <= '0;
            remaining <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (rd_acc && (bus.burstcount > BURST_WIDTH'(1))) begin
                        next_addr <= bus.address + ADDR_WIDTH'(1);
                        remaining <= bus.burstcount - BURST_WIDTH'(1);
                        state     <= BURST;
                    end
                end
                BURST: begin
                    next_addr <= next_addr + ADDR_WIDTH'(1);
                    remaining <= remaining - BURST_WIDTH'(1);
                    if (remaining == BURST_WIDTH'(1)) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < LANES; b++) begin
                if (bus.byteenable[b]) begin
                    mem[bus.address][b*8 +: 8] <= bus.writedata[b*8 +: 8];
                end
            end
        end
    end

    // Read return pipeline; data stages only load on a valid beat so readdata holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else if (en) begin
            vld_q[0] <= issue;
            if (issue) begin
                dat_q[0] <= mem[issue_addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_avalon_onchip_ram_burst.sv
// Scoreboard bench: one RAM with read latency 1 and one with latency 2 share the same
// stimulus; expected beats are queued per instance and popped by a monitor.
module tb_avalon_onchip_ram_burst;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned BW = 4;

    logic clk;
    logic reset;
    logic reset_req;
    logic clken;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp1 [$];
    logic [DW-1:0] exp2 [$];

    avalon_onchip_ram_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) b1 ();
    avalon_onchip_ram_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) b2 ();

    assign b2.chipselect = b1.chipselect;
    assign b2.address    = b1.address;
    assign b2.byteenable = b1.byteenable;
    assign b2.read       = b1.read;
    assign b2.write      = b1.write;
    assign b2.writedata  = b1.writedata;
    assign b2.burstcount = b1.burstcount;

    avalon_onchip_ram_burst #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .BURST_WIDTH(BW)
    ) dut1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .bus(b1)
    );

    avalon_onchip_ram_burst #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .BURST_WIDTH(BW)
    ) dut2 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .bus(b2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        b1.chipselect = 1'b0;
        b1.read       = 1'b0;
        b1.write      = 1'b0;
    endtask

    task automatic expect_beat(input logic [DW-1:0] d);
        exp1.push_back(d);
        exp2.push_back(d);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        b1.chipselect = 1'b1;
        b1.write      = 1'b1;
        b1.read       = 1'b0;
        b1.address    = a;
        b1.writedata  = d;
        b1.byteenable = be;
        @(negedge clk);
        chk("wr_waitrequest", 32'(b1.waitrequest), 32'd0);
        step();
        idle_bus();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [BW-1:0] bc);
        b1.chipselect = 1'b1;
        b1.read       = 1'b1;
        b1.write      = 1'b0;
        b1.address    = a;
        b1.burstcount = bc;
        @(negedge clk);
        chk("rd_waitrequest", 32'(b1.waitrequest), 32'd0);
        step();
        idle_bus();
    endtask

    // Monitor: every returned beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (b1.readdatavalid === 1'b1) begin
            if (exp1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rl1_extra_beat: got readdatavalid=1 readdata=%h, required readdatavalid=0", b1.readdata);
            end else begin
                chk("rl1_readdata", b1.readdata, exp1.pop_front());
            end
        end
        if (b2.readdatavalid === 1'b1) begin
            if (exp2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rl2_extra_beat: got readdatavalid=1 readdata=%h, required readdatavalid=0", b2.readdata);
            end else begin
                chk("rl2_readdata", b2.readdata, exp2.pop_front());
            end
        end
    end

    initial begin
        reset         = 1'b1;
        reset_req     = 1'b0;
        clken         = 1'b1;
        b1.chipselect = 1'b0;
        b1.read       = 1'b0;
        b1.write      = 1'b0;
        b1.address    = '0;
        b1.writedata  = '0;
        b1.byteenable = '0;
        b1.burstcount = '0;

        @(negedge clk);
        chk("reset_rdv1", 32'(b1.readdatavalid), 32'd0);
        chk("reset_rdv2", 32'(b2.readdatavalid), 32'd0);
        chk("reset_readdata1", b1.readdata, 32'd0);
        chk("reset_readdata2", b2.readdata, 32'd0);
        chk("reset_waitrequest", 32'(b1.waitrequest), 32'd0);
        step();
        reset = 1'b0;
        step();

        // single write then read on the very next cycle
        wr(8'h05, 32'hDEADBEEF, 4'hF);
        expect_beat(32'hDEADBEEF);
        rd(8'h05, 4'd1);
        @(negedge clk);
        chk("t1_rdv1_latency", 32'(b1.readdatavalid), 32'd1);
        chk("t1_rdv2_early", 32'(b2.readdatavalid), 32'd0);
        chk("t1_waitrequest", 32'(b1.waitrequest), 32'd0);
        step();
        @(negedge clk);
        chk("t1_rdv1_single", 32'(b1.readdatavalid), 32'd0);
        chk("t1_rdv2_latency", 32'(b2.readdatavalid), 32'd1);
        chk("t1_readdata_hold", b1.readdata, 32'hDEADBEEF);
        step();

        // byte-lane merge
        wr(8'h07, 32'h11223344, 4'hF);
        wr(8'h07, 32'hAABBCCDD, 4'h5);
        expect_beat(32'h11BB33DD);
        rd(8'h07, 4'd1);
        step();
        step();

        // burstcount 0 behaves as a single beat
        expect_beat(32'hDEADBEEF);
        rd(8'h05, 4'd0);
        @(negedge clk);
        chk("bc0_no_burst", 32'(b1.waitrequest), 32'd0);
        step();
        step();

        // wrapping burst of four
        wr(8'hFE, 32'd1, 4'hF);
        wr(8'hFF, 32'd2, 4'hF);
        wr(8'h00, 32'd3, 4'hF);
        wr(8'h01, 32'd4, 4'hF);
        expect_beat(32'd1);
        expect_beat(32'd2);
        expect_beat(32'd3);
        expect_beat(32'd4);
        rd(8'hFE, 4'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_waitrequest", 32'(b1.waitrequest), (i < 3) ? 32'd1 : 32'd0);
            chk("t3_rdv1_back2back", 32'(b1.readdatavalid), 32'd1);
            step();
        end
        step();
        step();

        // clken stall mid-burst
        wr(8'h10, 32'hA0, 4'hF);
        wr(8'h11, 32'hA1, 4'hF);
        wr(8'h12, 32'hA2, 4'hF);
        expect_beat(32'hA0);
        expect_beat(32'hA1);
        expect_beat(32'hA2);
        rd(8'h10, 4'd3);
        step();
        clken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_stall_waitrequest", 32'(b1.waitrequest), 32'd1);
            chk("t4_stall_rdv1", 32'(b1.readdatavalid), 32'd0);
            chk("t4_stall_rdv2", 32'(b2.readdatavalid), 32'd0);
            step();
        end
        clken = 1'b1;
        @(negedge clk);
        chk("t4_resume_rdv1", 32'(b1.readdatavalid), 32'd1);
        chk("t4_resume_waitrequest", 32'(b1.waitrequest), 32'd1);
        repeat (4) step();

        // read+write collision: write wins, no beat returned
        b1.chipselect = 1'b1;
        b1.read       = 1'b1;
        b1.write      = 1'b1;
        b1.address    = 8'h03;
        b1.writedata  = 32'h55;
        b1.byteenable = 4'hF;
        b1.burstcount = 4'd1;
        @(negedge clk);
        chk("t5_waitrequest", 32'(b1.waitrequest), 32'd0);
        step();
        idle_bus();
        @(negedge clk);
        chk("t5_no_rdv1", 32'(b1.readdatavalid), 32'd0);
        step();
        @(negedge clk);
        chk("t5_no_rdv2", 32'(b2.readdatavalid), 32'd0);
        step();
        expect_beat(32'h55);
        rd(8'h03, 4'd1);
        step();
        step();

        // reset_req blocks acceptance
        reset_req     = 1'b1;
        b1.chipselect = 1'b1;
        b1.read       = 1'b1;
        b1.address    = 8'h05;
        b1.burstcount = 4'd1;
        @(negedge clk);
        chk("rreq_waitrequest", 32'(b1.waitrequest), 32'd1);
        step();
        idle_bus();
        reset_req = 1'b0;
        repeat (3) step();

        // reset during a burst of eight
        wr(8'h20, 32'hB0, 4'hF);
        wr(8'h21, 32'hB1, 4'hF);
        wr(8'h22, 32'hB2, 4'hF);
        expect_beat(32'hB0);
        expect_beat(32'hB1);
        expect_beat(32'hB2);
        rd(8'h20, 4'd8);
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        #1;
        reset = 1'b1;
        exp1.delete();
        exp2.delete();
        #1;
        chk("t6_reset_rdv1", 32'(b1.readdatavalid), 32'd0);
        chk("t6_reset_rdv2", 32'(b2.readdatavalid), 32'd0);
        chk("t6_reset_readdata", b1.readdata, 32'd0);
        chk("t6_reset_waitrequest", 32'(b1.waitrequest), 32'd0);
        step();
        step();
        reset = 1'b0;
        expect_beat(32'd3);
        rd(8'h00, 4'd1);
        expect_beat(32'hDEADBEEF);
        rd(8'h05, 4'd1);
        repeat (5) step();

        chk("rl1_beats_outstanding", 32'(exp1.size()), 32'd0);
        chk("rl2_beats_outstanding", 32'(exp2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
